alu_cmd_issue: RTL

- Upstream command/response stage for the registered 16-bit ALU.
- Buffers operand/function commands in a small FIFO and issues one command at a time on the ALU A/B/ALU_FUN inputs.
- Waits the ALU's registered latency, then captures ALU_OUT plus the four class flags.
- Returns the captured result on a valid/ready response port, with a flag-consistency error bit.

---
 rtl/alu_cmd_issue.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issue.sv
// rtl/alu_cmd_issue.sv - command FIFO and single-issue sequencer for the registered 16-bit ALU
// Optional divide-by-zero short-circuit is built when ALU_DIVZ_CHECK_EN is defined.
`timescale 1ns/1ps
module alu_cmd_issue #(
    parameter int DATA_W  = 16,
    parameter int FUN_W   = 4,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [DATA_W-1:0]         cmd_a,
    input  logic [DATA_W-1:0]         cmd_b,
    input  logic [FUN_W-1:0]          cmd_fun,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [FUN_W-1:0]          alu_fun,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_arith_flag,
    input  logic                      alu_logic_flag,
    input  logic                      alu_cmp_flag,
    input  logic                      alu_shift_flag,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [3:0]                rsp_flags,
    output logic [FUN_W-1:0]          rsp_fun,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
    localparam logic [CW-1:0]    LAT_LAST = CW'(ALU_LAT - 1);
    localparam logic [FUN_W-1:0] FUN_NOP  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_CAPT,
        S_RESP
    } state_t;

    state_t state;
    logic [CW-1:0] lat_cnt;

    logic [DATA_W-1:0] fifo_a   [DEPTH];
    logic [DATA_W-1:0] fifo_b   [DEPTH];
    logic [FUN_W-1:0]  fifo_fun [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic [FUN_W-1:0]  head_fun;
    logic              head_divz;
    logic [3:0]        alu_flags;

    assign cmd_ready = (level != FULL_LVL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && (level != '0);
    assign head_a    = fifo_a[rd_ptr];
    assign head_b    = fifo_b[rd_ptr];
    assign head_fun  = fifo_fun[rd_ptr];
    assign alu_flags = {alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag};
    assign busy      = (state != S_IDLE);

`ifdef ALU_DIVZ_CHECK_EN
    localparam logic [FUN_W-1:0] FUN_DIV = FUN_W'(3);
    assign head_divz = (head_fun == FUN_DIV) && (head_b == '0);
`else
    assign head_divz = 1'b0;
`endif

    // Flag class the ALU is expected to raise for a given function code.
    function automatic logic [3:0] flag_class(input logic [FUN_W-1:0] f);
        logic [3:0] c;
        if (f <= FUN_W'(3))       c = 4'b1000;
        else if (f <= FUN_W'(9))  c = 4'b0100;
        else if (f <= FUN_W'(12)) c = 4'b0010;
        else if (f <= FUN_W'(14)) c = 4'b0001;
        else                      c = 4'b0000;
        return c;
    endfunction

    // Entry storage carries no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]   <= cmd_a;
            fifo_b[wr_ptr]   <= cmd_b;
            fifo_fun[wr_ptr] <= cmd_fun;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            lat_cnt   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= FUN_NOP;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_fun   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        rsp_fun <= head_fun;
                        if (head_divz) begin
                            // Short-circuit: the ALU never sees a zero divisor.
                            rsp_data  <= '1;
                            rsp_flags <= 4'b0000;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            alu_a   <= head_a;
                            alu_b   <= head_b;
                            alu_fun <= head_fun;
                            lat_cnt <= '0;
                            state   <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= S_CAPT;
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end
                S_CAPT: begin
                    rsp_data  <= alu_out;
                    rsp_flags <= alu_flags;
                    rsp_err   <= (alu_flags != flag_class(rsp_fun));
                    rsp_valid <= 1'b1;
                    alu_fun   <= FUN_NOP;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
